bcd_down_counter: RTL and testbench

Loadable multi-decade BCD down-counter (countdown timer), the counterpart to the team's BCD up-counters.
- Accepts a packed BCD preset and decrements it one count per enabled cycle, with digit-to-digit borrow.
- Flags expiry with a one-cycle done pulse.
- Used as a programmable delay or timeout generator, fed directly by BCD values from counters or switch inputs.

---
 rtl/bcd_down_counter.sv | 106 ++++++++++
 tb/tb_bcd_down_counter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_down_counter.sv
// Loadable multi-decade BCD countdown timer with one-cycle expiry pulse.
// Optional periodic mode: define BCD_DOWN_AUTO_RELOAD_EN to reload the last preset on expiry.
module bcd_down_counter #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  busy,
    output logic                  zero,
    output logic                  done,
    output logic                  load_err
);
    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] ONE = W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t         r_state, w_state_next;
    logic [W-1:0]   r_q, w_q_next;
    logic [W-1:0]   r_reload, w_reload_next;
    logic           r_done, w_done_next;
    logic           r_load_err, w_load_err_next;

    logic [W-1:0]       w_dec;
    logic [DIGITS-1:0]  w_borrow;
    logic [DIGITS-1:0]  w_nib_ok;
    logic               w_load_ok;

    // Borrow ripples upward only through digits that are already 0.
    assign w_borrow[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] w_nib;
            assign w_nib = r_q[4*gi +: 4];
            assign w_dec[4*gi +: 4] = !w_borrow[gi] ? w_nib :
                                      (w_nib == 4'd0) ? 4'd9 : (w_nib - 4'd1);
            assign w_nib_ok[gi] = (load_val[4*gi +: 4] <= 4'd9);
            if (gi < DIGITS - 1) begin : g_borrow
                assign w_borrow[gi+1] = w_borrow[gi] & (w_nib == 4'd0);
            end
        end
    endgenerate

    assign w_load_ok = &w_nib_ok;

    always_comb begin
        w_state_next    = r_state;
        w_q_next        = r_q;
        w_reload_next   = r_reload;
        w_done_next     = 1'b0;
        w_load_err_next = 1'b0;
        if (load) begin
            if (w_load_ok) begin
                w_q_next      = load_val;
                w_reload_next = load_val;
                w_state_next  = (load_val == '0) ? IDLE : RUN;
            end else begin
                w_load_err_next = 1'b1;
            end
        end else if (r_state == RUN && enable) begin
            if (r_q == ONE) begin
                w_done_next = 1'b1;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
                w_q_next     = r_reload;
`else
                w_q_next     = '0;
                w_state_next = EXPIRED;
`endif
            end else begin
                w_q_next = w_dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_q        <= '0;
            r_reload   <= '0;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_q        <= w_q_next;
            r_reload   <= w_reload_next;
            r_done     <= w_done_next;
            r_load_err <= w_load_err_next;
        end
    end

    assign Q        = r_q;
    assign busy     = (r_state == RUN);
    assign zero     = (r_q == '0);
    assign done     = r_done;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Self-checking bench for bcd_down_counter: directed scenarios plus randomized traffic
// against a decimal-arithmetic reference model.
module tb_bcd_down_counter;
    localparam int DIGITS = 4;
    localparam int W = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         enable = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] Q;
    logic         busy, zero, done, load_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: count kept as a plain integer, state as small int.
    localparam int M_IDLE = 0, M_RUN = 1, M_EXP = 2;
    int m_val = 0;
    int m_reload = 0;
    int m_state = M_IDLE;
    bit m_done = 0;
    bit m_err = 0;

    bcd_down_counter #(.DIGITS(DIGITS)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .load(load),
        .load_val(load_val), .Q(Q), .busy(busy), .zero(zero),
        .done(done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r = '0;
        int x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [W-1:0] b);
        for (int i = 0; i < DIGITS; i++)
            if (b[4*i +: 4] > 4'd9) return 0;
        return 1;
    endfunction

    function automatic int from_bcd(input logic [W-1:0] b);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(b[4*i +: 4]);
        return r;
    endfunction

    // Drives one cycle of inputs, advances the model, and waits until just after the edge.
    task automatic tick(input bit rn, input bit ld, input bit en, input logic [W-1:0] lv);
        reset_n = rn; load = ld; enable = en; load_val = lv;
        m_done = 0; m_err = 0;
        if (!rn) begin
            m_val = 0; m_reload = 0; m_state = M_IDLE;
        end else if (ld) begin
            if (bcd_ok(lv)) begin
                m_val = from_bcd(lv); m_reload = m_val;
                m_state = (m_val != 0) ? M_RUN : M_IDLE;
            end else begin
                m_err = 1;
            end
        end else if (m_state == M_RUN && en) begin
            if (m_val == 1) begin
                m_done = 1;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
                m_val = m_reload;
`else
                m_val = 0; m_state = M_EXP;
`endif
            end else begin
                m_val = m_val - 1;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        tick(0, 0, 0, '0);
        tick(0, 0, 1, '0);
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (Q !== 16'h0000 || zero !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || load_err !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_idle[%0d]: Q=%h zero=%b busy=%b done=%b err=%b, want Q=0000 zero=1 busy=0 done=0 err=0",
                         i, Q, zero, busy, done, load_err);
            end
            $display("reset_idle[%0d] Q=%h zero=%b busy=%b done=%b", i, Q, zero, busy, done);
            tick(1, 0, 1, '0);
        end
    endtask

    task automatic test_countdown();
        int want;
        tick(1, 1, 0, 16'h0012);
        n_cmp++;
        if (Q !== 16'h0012 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL countdown_load: Q=%h busy=%b, want 0012 busy=1", Q, busy);
        end
        for (int i = 1; i <= 17; i++) begin
            tick(1, 0, 1, '0);
            want = (i <= 12) ? 12 - i : 0;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
            want = (12 - (i % 12)) % 12;
            if (want == 0) want = 12;
`endif
            n_cmp++;
            if (Q !== to_bcd(want) || done !== m_done || busy !== (m_state == M_RUN) || zero !== (m_val == 0)) begin
                n_bad++;
                $display("FAIL countdown[%0d]: Q=%h done=%b busy=%b zero=%b, want Q=%h done=%b busy=%b zero=%b",
                         i, Q, done, busy, zero, to_bcd(want), m_done, m_state == M_RUN, m_val == 0);
            end
            $display("countdown[%0d] Q=%h done=%b busy=%b", i, Q, done, busy);
        end
    endtask

    task automatic test_borrow();
        logic [W-1:0] pre [3];
        logic [W-1:0] post [3];
        pre[0] = 16'h1000; post[0] = 16'h0999;
        pre[1] = 16'h9999; post[1] = 16'h9998;
        pre[2] = 16'h0100; post[2] = 16'h0099;
        for (int i = 0; i < 3; i++) begin
            tick(1, 1, 0, pre[i]);
            tick(1, 0, 1, '0);
            n_cmp++;
            if (Q !== post[i] || Q !== to_bcd(m_val)) begin
                n_bad++;
                $display("FAIL borrow[%0d]: Q=%h, want %h", i, Q, post[i]);
            end
            $display("borrow %h -> Q=%h", pre[i], Q);
        end
    endtask

    task automatic test_invalid_and_priority();
        tick(1, 1, 0, 16'h0051);
        tick(1, 0, 1, '0);
        tick(1, 1, 1, 16'h12A4);
        n_cmp++;
        if (Q !== 16'h0050 || load_err !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL invalid_load: Q=%h err=%b done=%b busy=%b, want 0050 err=1 done=0 busy=1", Q, load_err, done, busy);
        end
        $display("invalid_load Q=%h err=%b", Q, load_err);
        tick(1, 0, 1, '0);
        n_cmp++;
        if (Q !== 16'h0049 || load_err !== 1'b0) begin
            n_bad++;
            $display("FAIL invalid_continue: Q=%h err=%b, want 0049 err=0", Q, load_err);
        end
        $display("invalid_continue Q=%h err=%b", Q, load_err);
        tick(1, 1, 1, 16'h0007);
        n_cmp++;
        if (Q !== 16'h0007 || busy !== 1'b1 || load_err !== 1'b0) begin
            n_bad++;
            $display("FAIL load_priority: Q=%h busy=%b err=%b, want 0007 busy=1 err=0", Q, busy, load_err);
        end
        $display("load_priority Q=%h", Q);
    endtask

    task automatic test_gaps_and_reset();
        logic [W-1:0] exp_q [4];
        bit en_seq [4];
        exp_q[0] = 16'h0004; exp_q[1] = 16'h0004; exp_q[2] = 16'h0004; exp_q[3] = 16'h0003;
        en_seq[0] = 1; en_seq[1] = 0; en_seq[2] = 0; en_seq[3] = 1;
        tick(1, 1, 0, 16'h0005);
        for (int i = 0; i < 4; i++) begin
            tick(1, 0, en_seq[i], '0);
            n_cmp++;
            if (Q !== exp_q[i] || done !== 1'b0 || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL gaps[%0d]: Q=%h done=%b busy=%b, want %h done=0 busy=1", i, Q, done, busy, exp_q[i]);
            end
            $display("gaps[%0d] en=%0d Q=%h", i, en_seq[i], Q);
        end
        tick(0, 1, 1, 16'h0042);
        n_cmp++;
        if (Q !== 16'h0000 || busy !== 1'b0 || done !== 1'b0 || zero !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_reset: Q=%h busy=%b done=%b zero=%b, want 0000 0 0 1", Q, busy, done, zero);
        end
        $display("mid_reset Q=%h busy=%b", Q, busy);
        tick(1, 0, 1, '0);
        n_cmp++;
        if (Q !== 16'h0000 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_idle: Q=%h busy=%b, want 0000 busy=0", Q, busy);
        end
    endtask

`ifdef BCD_DOWN_AUTO_RELOAD_EN
    task automatic test_auto_reload();
        int seq [9] = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
        int pulses = 0;
        tick(1, 1, 0, 16'h0003);
        for (int i = 0; i < 9; i++) begin
            tick(1, 0, 1, '0);
            if (done) pulses++;
            n_cmp++;
            if (Q !== to_bcd(seq[i]) || busy !== 1'b1 || done !== (seq[i] == 3)) begin
                n_bad++;
                $display("FAIL auto_reload[%0d]: Q=%h busy=%b done=%b, want %h busy=1 done=%b",
                         i, Q, busy, done, to_bcd(seq[i]), seq[i] == 3);
            end
            $display("auto_reload[%0d] Q=%h done=%b", i, Q, done);
        end
        n_cmp++;
        if (pulses != 3) begin
            n_bad++;
            $display("FAIL auto_reload_pulses: got %0d, want 3", pulses);
        end
    endtask
`endif

    task automatic test_random();
        logic [W-1:0] lv;
        bit rn, ld, en;
        for (int i = 0; i < 400; i++) begin
            rn = ($urandom_range(0, 49) != 0);
            ld = ($urandom_range(0, 11) == 0);
            en = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: lv = W'($urandom);
                1: lv = to_bcd($urandom_range(0, 9999));
                default: lv = to_bcd($urandom_range(0, 25));
            endcase
            tick(rn, ld, en, lv);
            n_cmp++;
            if (Q !== to_bcd(m_val) || busy !== (m_state == M_RUN) || zero !== (m_val == 0) ||
                done !== m_done || load_err !== m_err || !bcd_ok(Q)) begin
                n_bad++;
                $display("FAIL random[%0d]: Q=%h busy=%b zero=%b done=%b err=%b, want Q=%h busy=%b zero=%b done=%b err=%b",
                         i, Q, busy, zero, done, load_err, to_bcd(m_val), m_state == M_RUN, m_val == 0, m_done, m_err);
            end
            $display("random[%0d] rn=%0d ld=%0d en=%0d lv=%h Q=%h done=%b err=%b", i, rn, ld, en, lv, Q, done, load_err);
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_borrow();
        test_invalid_and_priority();
        test_gaps_and_reset();
`ifdef BCD_DOWN_AUTO_RELOAD_EN
        test_auto_reload();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
